pipe_stage_skid: RTL

- Parametrised successor to the fixed inter-stage pipeline registers (EX/MEM style) of the RISC-V datapath.
- Replaces the bare enable with a valid/ready handshake, a 2-entry skid buffer, synchronous flush (bubble insertion) and an occupancy output.
- Control bits and payload are split, so that a bubble always presents all-zero control (no RegWrite/MemWrite) to the next stage.
- One instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), with widths set per boundary.

---
 rtl/pipe_pkg.sv | 74 +++++++
 rtl/pipe_entry.sv | 44 ++++
 rtl/pipe_stage_skid.sv | 97 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared widths and per-boundary bundle layouts for the pipeline registers.
// Stage code packs/unpacks ctrl and data fields by name through these structs.
package pipe_pkg;

    typedef struct packed {
        logic       pred_taken;
        logic       fetch_fault;
    } ifid_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_data_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [3:0] alu_op;
    } idex_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  funct3;
    } idex_data_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic [1:0] wb_sel;
    } exmem_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        zero;
    } exmem_data_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
    } memwb_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic [4:0]  rd;
    } memwb_data_t;

    localparam int IFID_CTRL_W  = $bits(ifid_ctrl_t);
    localparam int IFID_DATA_W  = $bits(ifid_data_t);
    localparam int IDEX_CTRL_W  = $bits(idex_ctrl_t);
    localparam int IDEX_DATA_W  = $bits(idex_data_t);
    localparam int EXMEM_CTRL_W = $bits(exmem_ctrl_t);
    localparam int EXMEM_DATA_W = $bits(exmem_data_t);
    localparam int MEMWB_CTRL_W = $bits(memwb_ctrl_t);
    localparam int MEMWB_DATA_W = $bits(memwb_data_t);

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: valid + ctrl + data with load, clear-ctrl and async reset.
// Ports: load_i/ctrl_i/data_i fill the slot, clr_i empties it (data kept).
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int DATA_W = EXMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Emptying zeroes ctrl so a bubble never carries RegWrite/MemWrite.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage register with valid/ready handshake, 2-entry skid and flush.
// Ports: in_* upstream, out_* downstream (main entry), flush, occupancy.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int DATA_W = EXMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              m_valid_q, s_valid_q;
    logic [CTRL_W-1:0] m_ctrl_q, s_ctrl_q;
    logic [DATA_W-1:0] m_data_q, s_data_q;

    logic              m_load, m_clr, s_load, s_clr;
    logic [CTRL_W-1:0] m_ctrl_d;
    logic [DATA_W-1:0] m_data_d;
    logic              acc, pop, m_free;

    // in_ready comes straight from the skid register: no comb path.
    assign in_ready  = ~s_valid_q;
    assign out_valid = m_valid_q;
    assign out_ctrl  = m_ctrl_q;
    assign out_data  = m_data_q;
    assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

    always_comb begin
        acc      = in_valid & in_ready;
        pop      = m_valid_q & out_ready;
        m_free   = ~m_valid_q | pop;
        m_load   = 1'b0;
        m_clr    = 1'b0;
        s_load   = 1'b0;
        s_clr    = 1'b0;
        // Skid content always drains into M before new input (FIFO order).
        m_ctrl_d = s_valid_q ? s_ctrl_q : in_ctrl;
        m_data_d = s_valid_q ? s_data_q : in_data;
        if (flush) begin
            m_clr = 1'b1;
            s_clr = 1'b1;
        end else if (m_free) begin
            if (s_valid_q) begin
                m_load = 1'b1;
                s_load = acc;
                s_clr  = ~acc;
            end else begin
                m_load = acc;
                m_clr  = ~acc;
            end
        end else begin
            s_load = acc;
        end
    end

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .load_i  (m_load),
        .clr_i   (m_clr),
        .ctrl_i  (m_ctrl_d),
        .data_i  (m_data_d),
        .valid_o (m_valid_q),
        .ctrl_o  (m_ctrl_q),
        .data_o  (m_data_q)
    );

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (s_load),
        .clr_i   (s_clr),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (s_valid_q),
        .ctrl_o  (s_ctrl_q),
        .data_o  (s_data_q)
    );

endmodule
